// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - RV32I load/store initiator for a word-only memory port
module lsu_mem_master #(
  parameter int unsigned MEM_BYTES  = 4096,
  parameter bit          ERR_ON_OOR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic        d_we,
  input  logic [31:0] d_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] d_addr_q;
  logic [31:0] d_wdata_q;
  logic        d_we_q;

  logic        acc_err_d;
  logic [31:0] ld_data_d;
  logic [31:0] merge_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign d_addr     = d_addr_q;
  assign d_wdata    = d_wdata_q;
  assign d_we       = d_we_q;

  // Classify the incoming request: misaligned, illegal funct3 or out of range
  always_comb begin
    logic misalign;
    logic illegal;
    logic oor;
    misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    illegal   = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                (req_we && req_funct3[2]);
    oor       = ERR_ON_OOR && (req_addr >= 32'(MEM_BYTES));
    acc_err_d = misalign || illegal || oor;
  end

  // Select the addressed lane of the memory word and extend it for loads
  always_comb begin
    ld_byte = d_rdata[7:0];
    case (lane_q)
      2'd1:    ld_byte = d_rdata[15:8];
      2'd2:    ld_byte = d_rdata[23:16];
      2'd3:    ld_byte = d_rdata[31:24];
      default: ld_byte = d_rdata[7:0];
    endcase
    ld_half = lane_q[1] ? d_rdata[31:16] : d_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data_d = {24'h0, ld_byte};
      3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data_d = {16'h0, ld_half};
      default: ld_data_d = d_rdata;
    endcase
  end

  // Splice store data into the old word for byte/halfword read-modify-write
  always_comb begin
    merge_d = d_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (lane_q)
        2'd0: merge_d[7:0]   = wdata_q[7:0];
        2'd1: merge_d[15:8]  = wdata_q[7:0];
        2'd2: merge_d[23:16] = wdata_q[7:0];
        2'd3: merge_d[31:24] = wdata_q[7:0];
        default: merge_d = d_rdata;
      endcase
    end else if (lane_q[1]) begin
      merge_d[31:16] = wdata_q;
    end else begin
      merge_d[15:0] = wdata_q;
    end
  end

  // Transaction FSM with registered response and memory-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      d_addr_q     <= 32'h0;
      d_wdata_q    <= 32'h0;
      d_we_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            funct3_q     <= req_funct3;
            lane_q       <= req_addr[1:0];
            wdata_q      <= req_wdata[15:0];
            resp_rdata_q <= 32'h0;
            if (acc_err_d) begin
              // Rejected requests never reach the memory port
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              resp_err_q <= 1'b0;
              d_addr_q   <= {req_addr[31:2], 2'b00};
              if (req_we && (req_funct3 == 3'b010)) begin
                d_we_q    <= 1'b1;
                d_wdata_q <= req_wdata;
                state_q   <= S_WRITE;
              end else begin
                state_q <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          if (we_q) begin
            d_wdata_q <= merge_d;
            d_we_q    <= 1'b1;
            state_q   <= S_WRITE;
          end else begin
            resp_rdata_q <= ld_data_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_WRITE: begin
          d_we_q       <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed bench for lsu_mem_master
module tb_lsu_mem_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic [31:0] d_rdata;

  logic [31:0] mem [0:1023];
  logic        poke_en;
  logic [9:0]  poke_idx;
  logic [31:0] poke_data;

  int checks;
  int failures;

  lsu_mem_master #(.MEM_BYTES(4096), .ERR_ON_OOR(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_we       (d_we),
    .d_rdata    (d_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: asynchronous read, write on the clock edge
  assign d_rdata = mem[d_addr[11:2]];
  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    else if (d_we) mem[d_addr[11:2]] <= d_wdata;
  end

  task automatic poke(input int idx, input logic [31:0] data);
    poke_en   = 1'b1;
    poke_idx  = idx[9:0];
    poke_data = data;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Issue one request from IDLE and record what the memory port and response did
  task automatic do_req(input logic we, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, output int resp_cyc, output logic [31:0] rdata,
                        output logic err, output int we_cyc, output int we_cnt,
                        output logic [31:0] we_data);
    int cyc;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = wd;
    resp_cyc = -1; we_cyc = -1; we_cnt = 0; rdata = 32'hx; err = 1'bx; we_data = 32'hx;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (cyc <= 8 && resp_cyc < 0) begin
      if (d_we) begin we_cnt++; we_cyc = cyc; we_data = d_wdata; end
      if (resp_valid) begin resp_cyc = cyc; rdata = resp_rdata; err = resp_err; end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
    checks++; if (d_we !== 1'b0) begin failures++; $display("FAIL reset_d_we got=%b exp=0", d_we); end
    checks++; if (d_addr !== 32'h0) begin failures++; $display("FAIL reset_d_addr got=%h exp=0", d_addr); end
    checks++; if (d_wdata !== 32'h0) begin failures++; $display("FAIL reset_d_wdata got=%h exp=0", d_wdata); end
  endtask

  task automatic test_loads;
    int rc, wc, wn; logic [31:0] rd, wdat; logic er;
    logic [2:0] f; logic [31:0] a, exp;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin f = 3'b000; a = 32'h100; exp = 32'hFFFFFFAA; end
        1: begin f = 3'b100; a = 32'h103; exp = 32'h00000080; end
        2: begin f = 3'b101; a = 32'h100; exp = 32'h0000F0AA; end
        3: begin f = 3'b001; a = 32'h102; exp = 32'hFFFF8077; end
        default: begin f = 3'b010; a = 32'h100; exp = 32'h8077F0AA; end
      endcase
      do_req(1'b0, f, a, 32'h0, rc, rd, er, wc, wn, wdat);
      checks++; if (rd !== exp) begin failures++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rd, exp); end
      checks++; if (rc !== 2) begin failures++; $display("FAIL load%0d_latency got=%0d exp=2", i, rc); end
      checks++; if (er !== 1'b0) begin failures++; $display("FAIL load%0d_err got=%b exp=0", i, er); end
      checks++; if (wn !== 0) begin failures++; $display("FAIL load%0d_d_we_count got=%0d exp=0", i, wn); end
    end
  endtask

  task automatic test_sub_word_stores;
    int rc, wc, wn; logic [31:0] rd, wdat; logic er;
    do_req(1'b1, 3'b000, 32'h101, 32'hDEAD5512, rc, rd, er, wc, wn, wdat);
    checks++; if (wn !== 1) begin failures++; $display("FAIL sb_we_count got=%0d exp=1", wn); end
    checks++; if (wc !== 2) begin failures++; $display("FAIL sb_we_cycle got=%0d exp=2", wc); end
    checks++; if (wdat !== 32'h807712AA) begin failures++; $display("FAIL sb_wdata got=%h exp=807712aa", wdat); end
    checks++; if (rc !== 3) begin failures++; $display("FAIL sb_latency got=%0d exp=3", rc); end
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL sb_resp got=%b/%h exp=0/0", er, rd); end
    do_req(1'b0, 3'b010, 32'h100, 32'h0, rc, rd, er, wc, wn, wdat);
    checks++; if (rd !== 32'h807712AA) begin failures++; $display("FAIL sb_readback got=%h exp=807712aa", rd); end
    poke(64, 32'h8077F0AA);
    do_req(1'b1, 3'b001, 32'h102, 32'h0000BEEF, rc, rd, er, wc, wn, wdat);
    checks++; if (wdat !== 32'hBEEFF0AA || wc !== 2) begin failures++; $display("FAIL sh_write got=%h@%0d exp=beeff0aa@2", wdat, wc); end
    checks++; if (rc !== 3) begin failures++; $display("FAIL sh_latency got=%0d exp=3", rc); end
    checks++; if (mem[64] !== 32'hBEEFF0AA) begin failures++; $display("FAIL sh_mem got=%h exp=beeff0aa", mem[64]); end
  endtask

  task automatic test_word_store;
    int rc, wc, wn; logic [31:0] rd, wdat; logic er;
    do_req(1'b1, 3'b010, 32'h104, 32'h12345678, rc, rd, er, wc, wn, wdat);
    checks++; if (wc !== 1 || wn !== 1) begin failures++; $display("FAIL sw_we got=cyc%0d/n%0d exp=cyc1/n1", wc, wn); end
    checks++; if (rc !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", rc); end
    checks++; if (mem[65] !== 32'h12345678) begin failures++; $display("FAIL sw_mem got=%h exp=12345678", mem[65]); end
  endtask

  task automatic test_errors;
    int rc, wc, wn; logic [31:0] rd, wdat; logic er;
    logic w; logic [2:0] f; logic [31:0] a;
    logic [31:0] snap0, snap1;
    snap0 = mem[64];
    snap1 = mem[65];
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin w = 1'b0; f = 3'b010; a = 32'h102; end
        1: begin w = 1'b1; f = 3'b001; a = 32'h101; end
        2: begin w = 1'b0; f = 3'b011; a = 32'h100; end
        3: begin w = 1'b1; f = 3'b100; a = 32'h100; end
        default: begin w = 1'b0; f = 3'b010; a = 32'h1000; end
      endcase
      do_req(w, f, a, 32'hCAFEF00D, rc, rd, er, wc, wn, wdat);
      checks++; if (rc !== 1) begin failures++; $display("FAIL err%0d_latency got=%0d exp=1", i, rc); end
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL err%0d_flag got=%b exp=1", i, er); end
      checks++; if (wn !== 0) begin failures++; $display("FAIL err%0d_d_we_count got=%0d exp=0", i, wn); end
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err%0d_rdata got=%h exp=0", i, rd); end
    end
    checks++; if (mem[64] !== snap0 || mem[65] !== snap1) begin failures++; $display("FAIL err_mem got=%h/%h exp=%h/%h", mem[64], mem[65], snap0, snap1); end
  endtask

  task automatic test_reset_mid_rmw;
    int rc, wc, wn; logic [31:0] rd, wdat; logic er;
    logic [31:0] snap;
    snap = mem[64];
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h100; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", req_ready); end
    checks++; if (d_we !== 1'b0 || d_addr !== 32'h0 || d_wdata !== 32'h0) begin failures++; $display("FAIL midrst_port got=%b/%h/%h exp=0/0/0", d_we, d_addr, d_wdata); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin failures++; $display("FAIL midrst_resp got=%b/%b exp=0/0", resp_valid, resp_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem[64] !== snap) begin failures++; $display("FAIL midrst_mem got=%h exp=%h", mem[64], snap); end
    do_req(1'b0, 3'b010, 32'h100, 32'h0, rc, rd, er, wc, wn, wdat);
    checks++; if (rd !== snap || rc !== 2) begin failures++; $display("FAIL midrst_next got=%h@%0d exp=%h@2", rd, rc, snap); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q[$];
    int last, idx, nacc, nresp;
    logic acc;
    poke(64, 32'h11111111);
    poke(65, 32'h22222222);
    poke(66, 32'h33333333);
    poke(67, 32'h44444444);
    last = -1; idx = 0; nacc = 0; nresp = 0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra_resp got=%h exp=none", resp_rdata); end
        else begin
          if (resp_rdata !== exp_q[0]) begin failures++; $display("FAIL b2b_rdata got=%h exp=%h", resp_rdata, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        nresp++;
      end
      acc = req_ready;
      if (acc) begin
        if (last >= 0) begin
          checks++; if (c - last != 3) begin failures++; $display("FAIL b2b_gap got=%0d exp=3", c - last); end
        end
        last = c;
        exp_q.push_back(mem[64 + idx]);
        nacc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx = (idx + 1) % 4;
        req_addr = 32'h100 + 32'(idx * 4);
      end
    end
    req_valid = 1'b0;
    for (int d = 0; d < 6; d++) begin
      if (resp_valid) begin
        checks++;
        if (exp_q.size() == 0 || resp_rdata !== exp_q[0]) begin failures++; $display("FAIL b2b_drain_rdata got=%h", resp_rdata); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        nresp++;
      end
      @(posedge clk); #1;
    end
    checks++; if (nresp != nacc || nacc != 7) begin failures++; $display("FAIL b2b_count got=resp%0d/acc%0d exp=7/7", nresp, nacc); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    poke_en = 1'b0; poke_idx = 10'h0; poke_data = 32'h0;
    #3;
    test_reset();
    @(posedge clk); #1;
    poke(64, 32'h8077F0AA);
    poke(65, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    test_loads();
    test_sub_word_stores();
    test_word_store();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the RV32I core execute stage and the word-only simulation memory data port.
- Issues word-aligned reads and writes to the memory. Performs byte and halfword stores by read-modify-write, because the memory has no byte enables.
- Extracts and sign- or zero-extends sub-word loads, and rejects misaligned, illegal or out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 4096: size of the backing memory in bytes. Any access with req_addr >= MEM_BYTES is out of range.
- ERR_ON_OOR, 1: 1 = out-of-range access returns an error; 0 = the address is passed through and aliases in memory.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request strobe.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU valid for loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; bits above the access size are ignored.
- resp_valid  out  1  single-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; high for misaligned, illegal funct3 or out-of-range access.
- d_addr  out  32  word-aligned memory address, {addr[31:2], 2'b00}.
- d_wdata  out  32  memory write data.
- d_we  out  1  memory write enable; memory writes on the clk edge.
- d_rdata  in  32  asynchronous memory read data (valid in the same cycle as d_addr).

Behaviour:
- Reset (asynchronous): state=IDLE; resp_valid, resp_err, resp_rdata, d_addr, d_wdata and d_we all 0; req_ready=1.
- Reset asserted mid-operation: state returns to IDLE and d_we drops combinationally. A pending RMW write is abandoned and memory is unchanged.
- Accept: in IDLE with req_valid=1, latch we, funct3, addr and wdata.
- Error check at accept:
  - H/HU with addr[0]=1 is misaligned; W with addr[1:0]!=0 is misaligned.
  - funct3 values 011, 110, 111 are illegal; store with funct3[2]=1 is illegal.
  - Any error → go to RESP with resp_err=1. No memory access is made and d_we stays 0.
- States: IDLE, READ, WRITE, RESP.
  - Load: IDLE→READ→RESP. In READ, d_addr is driven and d_rdata is captured and extended at the edge.
  - SW: IDLE→WRITE→RESP. d_we=1 for exactly the WRITE cycle, with d_wdata=latched wdata.
  - SB/SH: IDLE→READ→WRITE→RESP. The old word is captured in READ. In WRITE, d_wdata is the old word with the addressed byte lane (addr[1:0]) or half lane (addr[1]) replaced by wdata[7:0] or wdata[15:0].
  - RESP: resp_valid=1 for one cycle, then IDLE. req_ready=0 outside IDLE, so there are no back-to-back accepts within a transaction.
- Latency in cycles after the accept edge:
  - Load: resp_valid at cycle 2.
  - SW: write committed at end of cycle 1; resp_valid at cycle 2.
  - SB/SH: write committed at end of cycle 2; resp_valid at cycle 3.
  - Error: resp_valid at cycle 1.
- Load extraction:
  - Byte lane selected by addr[1:0]; half lane selected by addr[1].
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- d_we is never 1 outside WRITE. d_addr holds the latched aligned address in READ, WRITE and RESP, and is 0 in IDLE after reset.
- req_valid is ignored outside IDLE and is never queued.

Test Plan:
- Preload mem[0x100]=0x8077F0AA. LB 0x100 → resp_rdata=0xFFFFFFAA at cycle 2; LBU 0x103 → 0x00000080; LHU 0x100 → 0x0000F0AA; LH 0x102 → 0xFFFF8077; LW 0x100 → 0x8077F0AA; resp_err=0 in all cases.
- SB 0x101, wdata=0xDEAD5512 → d_we=1 only in cycle 2 with d_wdata=0x807712AA; resp_valid at cycle 3; a following LW 0x100 returns 0x807712AA.
- SH 0x102, wdata=0x0000BEEF → word becomes 0xBEEFF0AA; SW 0x104, wdata=0x12345678 → d_we in cycle 1, resp at cycle 2.
- Error cases, each giving resp_valid+resp_err at cycle 1, d_we never asserted and memory unchanged:
  - LW 0x102 (misaligned);
  - SH 0x101 (misaligned);
  - funct3=011 (illegal);
  - SBU, i.e. store with funct3=100 (illegal);
  - LW 0x1000 with ERR_ON_OOR=1 (out of range).
- Assert rst asynchronously during the READ cycle of SB 0x100 → state IDLE, outputs 0, no write occurs, mem[0x100] unchanged; the next request is accepted normally.
- req_valid held high continuously → req_ready pulses only in IDLE; for a load stream, successive accepts are 3 cycles apart; no request is lost or duplicated.
